// File: rtl/wb_write_buffer.sv
// wb_write_buffer -- posted-write buffer between a Wishbone slave port and a
// downstream Wishbone master (SRAM side).
//   Upstream writes are acked as soon as they are queued in a DEPTH-entry
//   FIFO. Upstream reads wait until the FIFO has drained, so a read never
//   passes an earlier acked write.
// Ports:
//   clk, rst_n       single clock, synchronous active-low reset
//   wbs_*            upstream slave: cyc/stb/we/addr/sel/data in, data/ack out
//   wbm_*            downstream master: cyc/stb/we/addr/sel/data out, data/ack in
//   buf_empty        FIFO empty and downstream FSM idle
module wb_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:2] wbs_addr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:2] wbm_addr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,
  output logic        buf_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:2]     rd_addr_q, rd_addr_d;
  logic [3:0]      rd_sel_q, rd_sel_d;

  logic [31:2]     fifo_addr [DEPTH];
  logic [3:0]      fifo_sel  [DEPTH];
  logic [31:0]     fifo_data [DEPTH];

  logic push, pop, rd_req;

  // The registered ack masks the request in its ack cycle, limiting the
  // upstream port to one transfer every two cycles.
  assign push   = wbs_cyc_i & wbs_stb_i & wbs_we_i & ~ack_q & (count_q < FULL);
  assign rd_req = wbs_cyc_i & wbs_stb_i & ~wbs_we_i & ~ack_q;
  assign pop    = (state_q == WRITE) & wbm_ack_i;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ack_d     = 1'b0;
    rdata_d   = '0;
    rd_addr_d = rd_addr_q;
    rd_sel_d  = rd_sel_q;

    case (state_q)
      // Queued writes win over a pending read; a read only starts once the
      // FIFO is empty, which enforces write-before-read ordering.
      IDLE: begin
        if (count_q != '0) begin
          state_d = WRITE;
        end else if (rd_req) begin
          state_d   = READ;
          rd_addr_d = wbs_addr_i;
          rd_sel_d  = wbs_sel_i;
        end
      end
      WRITE: if (wbm_ack_i) state_d = IDLE;
      // A read abandoned upstream still finishes downstream, but its ack
      // and data are dropped.
      READ: begin
        if (wbm_ack_i) begin
          state_d = IDLE;
          if (wbs_cyc_i & wbs_stb_i) begin
            ack_d   = 1'b1;
            rdata_d = wbm_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      ack_d    = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      rd_addr_q <= '0;
      rd_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      rd_addr_q <= rd_addr_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= wbs_addr_i;
      fifo_sel[wr_ptr_q]  <= wbs_sel_i;
      fifo_data[wr_ptr_q] <= wbs_data_i;
    end
  end

  // Downstream outputs decode straight from the state flop; IDLE drives all
  // zeros, giving the mandatory gap cycle after every transaction.
  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_addr_o = '0;
    wbm_sel_o  = '0;
    wbm_data_o = '0;
    case (state_q)
      WRITE: begin
        wbm_cyc_o  = 1'b1;
        wbm_stb_o  = 1'b1;
        wbm_we_o   = 1'b1;
        wbm_addr_o = fifo_addr[rd_ptr_q];
        wbm_sel_o  = fifo_sel[rd_ptr_q];
        wbm_data_o = fifo_data[rd_ptr_q];
      end
      READ: begin
        wbm_cyc_o  = 1'b1;
        wbm_stb_o  = 1'b1;
        wbm_addr_o = rd_addr_q;
        wbm_sel_o  = rd_sel_q;
      end
      default: ;
    endcase
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_data_o = rdata_q;
  assign buf_empty  = (count_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer (DEPTH=4). Inputs change 1ns after the
// rising edge; outputs are checked at that same point, i.e. they show the
// state produced by the edge just passed.
module tb_wb_write_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:2] wbs_addr_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_data_o;
  logic        wbs_ack_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:2] wbm_addr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_o;
  logic [31:0] wbm_data_i;
  logic        wbm_ack_i;
  logic        buf_empty;

  int checks = 0;
  int errors = 0;

  // drain() results
  int          n_wr, n_rd;
  logic        b2b, saw_ack;
  logic [31:2] first_addr, last_addr;

  wb_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_addr_i(wbs_addr_i), .wbs_sel_i(wbs_sel_i), .wbs_data_i(wbs_data_i),
    .wbs_data_o(wbs_data_o), .wbs_ack_o(wbs_ack_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_addr_o(wbm_addr_o), .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o),
    .wbm_data_i(wbm_data_i), .wbm_ack_i(wbm_ack_i), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic up_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic up_req(input logic we, input logic [31:2] a, input logic [31:0] d);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_addr_i = a; wbs_sel_i = 4'hF; wbs_data_i = d;
  endtask

  // One upstream write into a non-full buffer: ack the cycle after the edge.
  task automatic do_wr(input string tag, input logic [31:2] a, input logic [31:0] d);
    up_req(1'b1, a, d);
    tick();
    chk(tag, 32'(wbs_ack_o), 32'd1);
    up_idle();
    tick();
  endtask

  // Slave acks every cycle; log downstream transactions until buf_empty.
  task automatic drain();
    logic prev;
    n_wr = 0; n_rd = 0; b2b = 1'b0; saw_ack = 1'b0; prev = 1'b0;
    first_addr = '0; last_addr = '0;
    wbm_ack_i = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (wbs_ack_o) saw_ack = 1'b1;
      if (wbm_cyc_o) begin
        if (prev) b2b = 1'b1;
        if (wbm_we_o) begin
          if (n_wr == 0) first_addr = wbm_addr_o;
          last_addr = wbm_addr_o;
          n_wr++;
        end else n_rd++;
      end
      prev = wbm_cyc_o;
      if (buf_empty && k > 0) break;
      tick();
    end
    wbm_ack_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; up_idle();
    wbs_addr_i = '0; wbs_sel_i = '0; wbs_data_i = '0;
    wbm_data_i = '0; wbm_ack_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ack",   32'(wbs_ack_o), 32'd0);
    chk("rst_data",  wbs_data_o,     32'd0);
    chk("rst_cyc",   32'(wbm_cyc_o), 32'd0);
    chk("rst_empty", 32'(buf_empty), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single write 0x100 <- DEADBEEF
    up_req(1'b1, 30'h40, 32'hDEADBEEF);
    tick();
    chk("w1_ack", 32'(wbs_ack_o), 32'd1);
    up_idle();
    tick();
    chk("w1_ack_pulse", 32'(wbs_ack_o), 32'd0);
    chk("w1_cyc",   32'(wbm_cyc_o),  32'd1);
    chk("w1_we",    32'(wbm_we_o),   32'd1);
    chk("w1_addr",  32'(wbm_addr_o), 32'h40);
    chk("w1_sel",   32'(wbm_sel_o),  32'hF);
    chk("w1_data",  wbm_data_o,      32'hDEADBEEF);
    chk("w1_busy",  32'(buf_empty),  32'd0);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("w1_idle",  32'(wbm_cyc_o),  32'd0);
    chk("w1_empty", 32'(buf_empty),  32'd1);

    // Full FIFO: 4 writes accepted, 5th stalls until a pop
    for (int i = 0; i < 4; i++) do_wr($sformatf("full_wr%0d", i), 30'(32'h200 + i), 32'hA0 + i);
    up_req(1'b1, 30'h204, 32'hA4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("full_stall%0d", i), 32'(wbs_ack_o), 32'd0);
    end
    chk("full_head", 32'(wbm_addr_o), 32'h200);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("full_pop_edge", 32'(wbs_ack_o), 32'd0);
    tick();
    chk("full_5th_ack", 32'(wbs_ack_o), 32'd1);
    up_idle();

    // Continuous-ack slave drains the 4 remaining entries with gaps
    drain();
    chk("cont_nwr",   32'(n_wr),       32'd4);
    chk("cont_gap",   32'(b2b),        32'd0);
    chk("cont_first", 32'(first_addr), 32'h201);
    chk("cont_last",  32'(last_addr),  32'h204);
    chk("cont_empty", 32'(buf_empty),  32'd1);

    // Write then read of same address, slow slave
    up_req(1'b1, 30'h10, 32'h12345678);
    tick();
    chk("rw_wack", 32'(wbs_ack_o), 32'd1);
    up_req(1'b0, 30'h10, 32'h0);
    tick();
    chk("rw_wr_first", 32'(wbm_we_o),   32'd1);
    chk("rw_wr_addr",  32'(wbm_addr_o), 32'h10);
    chk("rw_wr_data",  wbm_data_o,      32'h12345678);
    tick(); tick();
    chk("rw_wait_ack", 32'(wbs_ack_o), 32'd0);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("rw_gap", 32'(wbm_cyc_o), 32'd0);
    tick();
    chk("rw_rd_cyc",  32'(wbm_cyc_o),  32'd1);
    chk("rw_rd_we",   32'(wbm_we_o),   32'd0);
    chk("rw_rd_addr", 32'(wbm_addr_o), 32'h10);
    chk("rw_rd_wdat", wbm_data_o,      32'd0);
    tick(); tick();
    chk("rw_rd_wait", 32'(wbs_ack_o), 32'd0);
    wbm_data_i = 32'h12345678; wbm_ack_i = 1'b1;
    tick();
    wbm_data_i = '0; wbm_ack_i = 1'b0;
    chk("rw_rd_ack",  32'(wbs_ack_o), 32'd1);
    chk("rw_rd_data", wbs_data_o,     32'h12345678);
    up_idle();
    tick();
    chk("rw_data_clr", wbs_data_o, 32'd0);

    // Read waiting behind 3 writes, aborted before drain
    for (int i = 0; i < 3; i++) do_wr($sformatf("ab_wr%0d", i), 30'(32'h300 + i), 32'hB0 + i);
    up_req(1'b0, 30'h300, 32'h0);
    tick(); tick();
    chk("ab_wait_ack", 32'(wbs_ack_o), 32'd0);
    up_idle();
    tick();
    drain();
    chk("ab_nwr", 32'(n_wr),    32'd3);
    chk("ab_nrd", 32'(n_rd),    32'd0);
    chk("ab_ack", 32'(saw_ack), 32'd0);
    tick(); tick();
    chk("ab_quiet", 32'(wbm_cyc_o), 32'd0);

    // Reset during WRITE with 2 entries queued
    do_wr("rst_wr0", 30'h400, 32'hC0);
    do_wr("rst_wr1", 30'h401, 32'hC1);
    chk("rst_mid_busy", 32'(wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_cyc",   32'(wbm_cyc_o), 32'd0);
    chk("rst_mid_empty", 32'(buf_empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_mid_quiet%0d", i), 32'(wbm_cyc_o), 32'd0);
    end

    // Upstream abort during READ: downstream finishes, no upstream ack
    up_req(1'b0, 30'h33, 32'h0);
    tick();
    chk("rab_cyc",  32'(wbm_cyc_o),  32'd1);
    chk("rab_addr", 32'(wbm_addr_o), 32'h33);
    up_idle();
    tick();
    chk("rab_hold", 32'(wbm_cyc_o), 32'd1);
    wbm_data_i = 32'hCAFE; wbm_ack_i = 1'b1;
    tick();
    wbm_data_i = '0; wbm_ack_i = 1'b0;
    chk("rab_noack",  32'(wbs_ack_o), 32'd0);
    chk("rab_nodata", wbs_data_o,     32'd0);
    chk("rab_idle",   32'(wbm_cyc_o), 32'd0);
    chk("rab_empty",  32'(buf_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
